// File: rtl/mmu_tlb_if.sv
// Core-side bundle for mmu_tlb: translation request/response and TLB maintenance ops.
// Entry packing, LSB first: v, d, c, pfn[19:0], g, asid[7:0], vpn[19:0] (52 bits).
interface mmu_tlb_if #(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned ENTRY_W = 52
);
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_vaddr;
    logic               req_store;
    logic [7:0]         cur_asid;
    logic               rsp_valid;
    logic [31:0]        rsp_paddr;
    logic               rsp_cached;
    logic [1:0]         rsp_exc;
    logic               op_valid;
    logic [1:0]         op_code;
    logic [IDX_W-1:0]   op_index;
    logic [ENTRY_W-1:0] op_wentry;
    logic               op_busy;
    logic               op_done;
    logic [ENTRY_W-1:0] op_rentry;
    logic [IDX_W-1:0]   op_pindex;
    logic               op_pmiss;

    modport master (
        output req_valid, req_vaddr, req_store, cur_asid,
        output op_valid, op_code, op_index, op_wentry,
        input  req_ready, rsp_valid, rsp_paddr, rsp_cached, rsp_exc,
        input  op_busy, op_done, op_rentry, op_pindex, op_pmiss
    );

    modport slave (
        input  req_valid, req_vaddr, req_store, cur_asid,
        input  op_valid, op_code, op_index, op_wentry,
        output req_ready, rsp_valid, rsp_paddr, rsp_cached, rsp_exc,
        output op_busy, op_done, op_rentry, op_pindex, op_pmiss
    );
endinterface

// File: rtl/mmu_tlb.sv
// Address translation: kseg0/kseg1 direct-mapped, other segments via a fully associative
// 4KB-page TLB with ASID match, plus write-indexed/write-random/probe/read maintenance ops.
module mmu_tlb #(
    parameter int unsigned TLB_ENTRIES  = 16,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned WIRED        = 0,
    parameter bit          KSEG0_CACHED = 1'b1
) (
    input logic      clk,
    input logic      resetn,
    mmu_tlb_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [IDX_W-1:0] WIRED_IDX  = IDX_W'(WIRED);
    localparam bit               RAND_FIXED = (WIRED >= TLB_ENTRIES - 1);

    typedef enum logic [1:0] {StIdle, StOp, StDone} state_e;

    typedef struct packed {
        logic [19:0] vpn;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn;
        logic        c;
        logic        d;
        logic        v;
    } entry_t;

    state_e                 state_q;
    logic                   ready_q;
    logic [IDX_W-1:0]       rand_q, rand_d;
    entry_t                 tlb_q [TLB_ENTRIES];
    // A slot only takes part in matching once it has been written since reset.
    logic [TLB_ENTRIES-1:0] slot_q;
    logic [1:0]             op_code_q;
    logic [IDX_W-1:0]       op_index_q;
    entry_t                 op_wentry_q;
    logic                   busy_q, done_q, pmiss_q;
    entry_t                 rentry_q;
    logic [IDX_W-1:0]       pindex_q;
    logic                   rsp_valid_q, rsp_cached_q;
    logic [31:0]            rsp_paddr_q;
    logic [1:0]             rsp_exc_q;

    logic             accept;
    logic             hit, pr_hit;
    entry_t           hit_e;
    logic [IDX_W-1:0] pr_idx;
    logic [31:0]      lk_paddr;
    logic             lk_cached;
    logic [1:0]       lk_exc;

    assign bus.req_ready  = (state_q == StIdle) & ~bus.op_valid & ready_q;
    assign accept         = bus.req_valid & bus.req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_paddr  = rsp_paddr_q;
    assign bus.rsp_cached = rsp_cached_q;
    assign bus.rsp_exc    = rsp_exc_q;
    assign bus.op_busy    = busy_q;
    assign bus.op_done    = done_q;
    assign bus.op_rentry  = rentry_q;
    assign bus.op_pindex  = pindex_q;
    assign bus.op_pmiss   = pmiss_q;

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        hit   = 1'b0;
        hit_e = '0;
        for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
            if (slot_q[i] && tlb_q[i].vpn == bus.req_vaddr[31:12] &&
                (tlb_q[i].g || tlb_q[i].asid == bus.cur_asid)) begin
                hit   = 1'b1;
                hit_e = tlb_q[i];
            end
        end
    end

    always_comb begin
        pr_hit = 1'b0;
        pr_idx = '0;
        for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
            if (slot_q[i] && tlb_q[i].vpn == op_wentry_q.vpn &&
                (tlb_q[i].g || tlb_q[i].asid == op_wentry_q.asid)) begin
                pr_hit = 1'b1;
                pr_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        lk_paddr  = '0;
        lk_cached = 1'b0;
        lk_exc    = 2'b00;
        case (bus.req_vaddr[31:29])
            3'b100: begin
                lk_paddr  = {3'b000, bus.req_vaddr[28:0]};
                lk_cached = KSEG0_CACHED;
            end
            3'b101: lk_paddr = {3'b000, bus.req_vaddr[28:0]};
            default: begin
                if (!hit) begin
                    lk_exc = 2'b01;
                end else if (!hit_e.v) begin
                    lk_exc = 2'b10;
                end else if (bus.req_store && !hit_e.d) begin
                    lk_exc = 2'b11;
                end else begin
                    lk_paddr  = {hit_e.pfn, bus.req_vaddr[11:0]};
                    lk_cached = hit_e.c;
                end
            end
        endcase
    end

    always_comb begin
        if (RAND_FIXED || rand_q <= WIRED_IDX) rand_d = LAST_IDX;
        else                                   rand_d = rand_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid_q  <= 1'b0;
            rsp_paddr_q  <= '0;
            rsp_cached_q <= 1'b0;
            rsp_exc_q    <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_paddr_q  <= lk_paddr;
                rsp_cached_q <= lk_cached;
                rsp_exc_q    <= lk_exc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            rand_q      <= LAST_IDX;
            slot_q      <= '0;
            for (int i = 0; i < int'(TLB_ENTRIES); i++) tlb_q[i] <= '0;
            op_code_q   <= '0;
            op_index_q  <= '0;
            op_wentry_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rentry_q    <= '0;
            pindex_q    <= '0;
            pmiss_q     <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            rand_q  <= rand_d;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.op_valid) begin
                        op_code_q   <= bus.op_code;
                        op_index_q  <= bus.op_index;
                        op_wentry_q <= bus.op_wentry;
                        busy_q      <= 1'b1;
                        state_q     <= StOp;
                    end
                end
                StOp: begin
                    unique case (op_code_q)
                        2'b00: begin
                            tlb_q[op_index_q]  <= op_wentry_q;
                            slot_q[op_index_q] <= 1'b1;
                        end
                        2'b01: begin
                            tlb_q[rand_q]  <= op_wentry_q;
                            slot_q[rand_q] <= 1'b1;
                        end
                        2'b10: begin
                            pindex_q <= pr_hit ? pr_idx : '0;
                            pmiss_q  <= ~pr_hit;
                        end
                        2'b11: rentry_q <= tlb_q[op_index_q];
                    endcase
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb: a table-level reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized request/op mix.
module tb_mmu_tlb;
    localparam int N     = 16;
    localparam int IW    = 4;
    localparam int WIRED = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mmu_tlb_if #(.IDX_W(IW), .ENTRY_W(52)) bus ();

    mmu_tlb #(
        .TLB_ENTRIES (N),
        .IDX_W       (IW),
        .WIRED       (WIRED),
        .KSEG0_CACHED(1'b1)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rsp_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: table contents plus expected outputs, advanced once per clock.
    logic [51:0] m_tlb [N];
    bit          m_slot [N];
    int          cyc, phase;
    logic [1:0]  m_code;
    logic [IW-1:0] m_idx;
    logic [51:0] m_went;
    bit          e_rsp_valid, e_cached, e_done, e_pmiss, acc;
    logic [31:0] e_paddr;
    logic [1:0]  e_exc;
    logic [51:0] e_rentry;
    logic [IW-1:0] e_pindex;

    function automatic int rnd_at(input int n);
        return (N - 1) - (n % (N - WIRED));
    endfunction

    function automatic int find(input logic [19:0] vpn, input logic [7:0] asid);
        logic [51:0] e;
        for (int i = 0; i < N; i++) begin
            e = m_tlb[i];
            if (m_slot[i] && e[51:32] == vpn && (e[23] || e[31:24] == asid)) return i;
        end
        return -1;
    endfunction

    function automatic void xlate(input logic [31:0] va, input bit st, input logic [7:0] asid,
                                  output logic [31:0] pa, output bit ca, output logic [1:0] ex);
        int h;
        logic [51:0] e;
        pa = 32'h0; ca = 1'b0; ex = 2'b00;
        if (va[31:29] == 3'b100) begin
            pa = va & 32'h1FFF_FFFF;
            ca = 1'b1;
        end else if (va[31:29] == 3'b101) begin
            pa = va & 32'h1FFF_FFFF;
        end else begin
            h = find(va[31:12], asid);
            if (h < 0) ex = 2'b01;
            else begin
                e = m_tlb[h];
                if (!e[0]) ex = 2'b10;
                else if (st && !e[1]) ex = 2'b11;
                else begin
                    pa = {e[22:3], va[11:0]};
                    ca = e[2];
                end
            end
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                for (int i = 0; i < N; i++) begin
                    m_tlb[i] = '0;
                    m_slot[i] = 1'b0;
                end
                cyc = 0; phase = 0; e_rsp_valid = 0; e_done = 0;
                e_rentry = '0; e_pindex = '0; e_pmiss = 0;
            end else begin
                acc = bus.req_valid && !bus.op_valid && phase == 0 && cyc >= 1;
                e_rsp_valid = acc;
                if (acc) xlate(bus.req_vaddr, bus.req_store, bus.cur_asid, e_paddr, e_cached, e_exc);
                e_done = 1'b0;
                if (phase == 0) begin
                    if (bus.op_valid) begin
                        m_code = bus.op_code; m_idx = bus.op_index; m_went = bus.op_wentry;
                        phase = 1;
                    end
                end else if (phase == 1) begin
                    case (m_code)
                        2'b00: begin m_tlb[m_idx] = m_went; m_slot[m_idx] = 1'b1; end
                        2'b01: begin m_tlb[rnd_at(cyc)] = m_went; m_slot[rnd_at(cyc)] = 1'b1; end
                        2'b10: begin
                            e_pmiss  = find(m_went[51:32], m_went[31:24]) < 0;
                            e_pindex = e_pmiss ? '0 : IW'(find(m_went[51:32], m_went[31:24]));
                        end
                        default: e_rentry = m_tlb[m_idx];
                    endcase
                    e_done = 1'b1;
                    phase = 2;
                end else begin
                    phase = 0;
                end
                cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                check("req_ready", bus.req_ready, phase == 0 && !bus.op_valid && cyc >= 1);
                check("rsp_valid", bus.rsp_valid, e_rsp_valid);
                if (e_rsp_valid) begin
                    check("rsp_paddr", bus.rsp_paddr, e_paddr);
                    check("rsp_cached", bus.rsp_cached, e_cached);
                    check("rsp_exc", bus.rsp_exc, e_exc);
                end
                check("op_busy", bus.op_busy, phase != 0);
                check("op_done", bus.op_done, e_done);
                check("op_pindex", bus.op_pindex, e_pindex);
                check("op_pmiss", bus.op_pmiss, e_pmiss);
                check("op_rentry", bus.op_rentry, e_rentry);
                if (bus.rsp_valid) rsp_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (bus.op_done) seen = 1'b1;
        end
        if (!seen) check("op_done timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input logic [1:0] code, input logic [IW-1:0] idx, input logic [51:0] we);
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.op_code = code; bus.op_index = idx; bus.op_wentry = we;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        wait_done();
    endtask

    task automatic lk(input logic [31:0] va, input bit st, input logic [7:0] asid,
                      input logic [31:0] ep, input bit ec, input logic [1:0] ee, input string nm);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_vaddr = va; bus.req_store = st; bus.cur_asid = asid;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check({nm, " valid"}, bus.rsp_valid, 1'b1);
        check({nm, " paddr"}, bus.rsp_paddr, ep);
        check({nm, " cached"}, bus.rsp_cached, ec);
        check({nm, " exc"}, bus.rsp_exc, ee);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " req_ready"}, bus.req_ready, 1'b0);
        check({nm, " rsp_valid"}, bus.rsp_valid, 1'b0);
        check({nm, " rsp_paddr"}, bus.rsp_paddr, 32'h0);
        check({nm, " op_busy"}, bus.op_busy, 1'b0);
        check({nm, " op_done"}, bus.op_done, 1'b0);
        check({nm, " op_pmiss"}, bus.op_pmiss, 1'b0);
        check({nm, " op_rentry"}, bus.op_rentry, 52'h0);
    endtask

    logic [19:0] vpns [4] = '{20'h00400, 20'h00401, 20'hC0000, 20'h7FFFF};

    function automatic logic [51:0] rnd_entry();
        return {vpns[$urandom_range(0, 3)], 8'(5 + $urandom_range(0, 2)),
                1'($urandom_range(0, 3) == 0), 20'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
    endfunction

    localparam logic [51:0] ENT3 = {20'h00400, 8'd5, 1'b0, 20'h12345, 1'b1, 1'b0, 1'b1};
    localparam logic [51:0] ENT7 = {20'h00400, 8'd9, 1'b0, 20'h0ABCD, 1'b1, 1'b1, 1'b0};

    initial begin
        int k, cycles, low, rs0, sel;
        bit pred;
        bus.req_valid = 0; bus.req_vaddr = '0; bus.req_store = 0; bus.cur_asid = '0;
        bus.op_valid = 0; bus.op_code = '0; bus.op_index = '0; bus.op_wentry = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2 resetn = 1'b1;
        @(negedge clk);
        check("first cycle req_ready", bus.req_ready, 1'b0);

        lk(32'h9FC0_0100, 0, 8'd0, 32'h1FC0_0100, 1, 2'b00, "kseg0");
        lk(32'hBFC0_0100, 0, 8'd0, 32'h1FC0_0100, 0, 2'b00, "kseg1");

        do_op(2'b00, 4'd3, ENT3);
        lk(32'h0040_0ABC, 0, 8'd5, 32'h1234_5ABC, 1, 2'b00, "mapped hit");
        lk(32'h0040_0ABC, 0, 8'd6, 32'h0, 0, 2'b01, "asid miss");
        lk(32'h0040_0ABC, 1, 8'd5, 32'h0, 0, 2'b11, "store clean");

        do_op(2'b00, 4'd7, ENT7);
        lk(32'h0040_0000, 0, 8'd9, 32'h0, 0, 2'b10, "invalid");
        lk(32'h7000_0000, 0, 8'd5, 32'h0, 0, 2'b01, "refill");

        do_op(2'b10, 4'd0, {20'h00400, 8'd5, 24'h0});
        check("probe idx", bus.op_pindex, 4'd3);
        check("probe miss", bus.op_pmiss, 1'b0);
        do_op(2'b10, 4'd0, {20'h00401, 8'd5, 24'h0});
        check("probe2 miss", bus.op_pmiss, 1'b1);
        check("probe2 idx", bus.op_pindex, 4'd0);
        do_op(2'b11, 4'd3, 52'h0);
        check("read idx3", bus.op_rentry, ENT3);

        // Back-to-back stream with an op landing mid-stream.
        rs0 = rsp_seen; low = 0; k = 0; cycles = 0;
        @(posedge clk);
        while (k < 8 && cycles < 40) begin
            #1;
            bus.req_valid = 1'b1;
            bus.req_vaddr = (k % 2 == 1) ? 32'h0040_0000 + 32'(k * 16) : 32'hA000_0000 + 32'(k * 16);
            bus.req_store = 1'b0; bus.cur_asid = 8'd5;
            bus.op_valid = (cycles == 3); bus.op_code = 2'b11; bus.op_index = 4'd7;
            pred = phase == 0 && !bus.op_valid && cyc >= 1;
            @(negedge clk);
            if (!bus.req_ready) low++;
            @(posedge clk);
            if (pred) k++;
            cycles++;
        end
        #1 bus.req_valid = 1'b0; bus.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stream responses", 64'(rsp_seen - rs0), 64'd8);
        check("stream ready low", 64'(low), 64'd3);

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            sel = $urandom_range(0, 9);
            bus.req_valid = $urandom_range(0, 3) != 0;
            if (sel == 0)      bus.req_vaddr = {3'b100, 29'($urandom)};
            else if (sel == 1) bus.req_vaddr = {3'b101, 29'($urandom)};
            else               bus.req_vaddr = {vpns[$urandom_range(0, 3)], 12'($urandom)};
            bus.req_store = 1'($urandom_range(0, 1));
            bus.cur_asid = 8'(5 + $urandom_range(0, 2));
            bus.op_valid = $urandom_range(0, 9) == 0;
            bus.op_code = 2'($urandom_range(0, 3));
            bus.op_index = IW'($urandom_range(0, N - 1));
            bus.op_wentry = rnd_entry();
        end
        @(posedge clk); #1 bus.req_valid = 1'b0; bus.op_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Reset while an op is in its OP cycle.
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.op_code = 2'b00; bus.op_index = 4'd2; bus.op_wentry = ENT3;
        @(posedge clk); #1 bus.op_valid = 1'b0;
        #2 resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid-op reset");
        @(posedge clk); #2 resetn = 1'b1;
        lk(32'h0040_0ABC, 0, 8'd5, 32'h0, 0, 2'b01, "after reset");

        for (int i = 0; i < 40; i++)
            do_op(2'b01, 4'd0, {20'(20'h10000 + i), 8'd1, 1'b0, 20'(i), 1'b1, 1'b1, 1'b1});
        for (int i = 0; i < N; i++) begin
            do_op(2'b11, IW'(i), 52'h0);
            if (i < WIRED) check("wired untouched", bus.op_rentry, 52'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
